alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
// Registered, parametrised ALU execution stage for the IDIOT processor. It replaces the bare
// "Z <= z" result latch with a valid/ready-handshaked stage of configurable word width.
// Shift operations run iteratively, one bit per cycle, under a small FSM.
// Control sits upstream and writeback (register file / memory) sits downstream.
// PARAMETERS
// WIDTH   16  operand/result width in bits (>=4, power of two)
// SHW     4   shift-count width = log2(WIDTH); only Y[SHW-1:0] is used as the shift amount
// PORTS
// clk        in   1      rising-edge clock
// reset      in   1      asynchronous, active-low reset
// in_valid   in   1      X/Y/op are valid this cycle
// in_ready   out  1      stage accepts an operation this cycle
// op         in   3      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(X), 6 SHL, 7 SHR (logical)
// X          in   WIDTH  operand A
// Y          in   WIDTH  operand B (for shifts: the amount in Y[SHW-1:0])
// out_valid  out  1      Z holds a result
// out_ready  in   1      downstream takes Z this cycle
// Z          out  WIDTH  registered result
// flags      out  3      {C,N,Z0}; present only with ALU_FLAGS_EN
// BEHAVIOUR
// - Reset (async, reset==0): state=IDLE, out_valid=0, Z=0, flags=0. in_ready=0 while in reset.
// - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
// - in_ready = (state==IDLE) & (!out_valid | out_ready). The same-cycle drain+accept path
//   gives full throughput for single-cycle ops.
// - FSM states:
//   - IDLE: on accept of ops 0-5, or of 6/7 with amount 0: Z<=result and out_valid<=1 next edge
//     (latency 1). On accept of 6/7 with amount n>0: latch X to the shift reg, cnt<=n,
//     go to SHIFT.
//   - SHIFT: shift by 1 per cycle and decrement cnt. When cnt reaches 1, the final shifted value
//     goes to Z, out_valid<=1, and the FSM returns to IDLE. A shift by n has latency n cycles.
//     in_ready=0 throughout SHIFT.
// - Holding: while out_valid & !out_ready, Z/flags hold stable and in_ready=0.
//   out_valid drops on an out transfer with no new completion in the same cycle.
// - Arithmetic: ADD/SUB are modulo 2^WIDTH. SUB is X + ~Y + 1. Shifts fill with 0.
// - Inputs are sampled only on accept; X/Y/op changes while in_ready=0 are ignored.
// - An async reset mid-SHIFT aborts the operation: no result is produced and Z=0.
// CONFIGURATION
// - ALU_FLAGS_EN defined: flags register, updated with Z.
//   - C = carry out (ADD), not-borrow (SUB), last bit shifted out (SHL/SHR with amount>0),
//     0 otherwise.
//   - N = Z[WIDTH-1]. Z0 = (Z==0).
// - ALU_FLAGS_EN undefined: no flags port and no flag logic.
// STRUCTURE
// - Shared package (signals.v): op-code defines (ALU_ADD..ALU_SHR) and the WORD width macro
//   derived from WIDTH. FSM state encodings stay local.
// - Sub-module alu_shift_unit: holds the shift register, count, and one-bit step logic.
//   The top holds the handshake, FSM, and single-cycle ops.
// TESTING
// 1. Reset low for 2 cycles: out_valid=0, Z=0, in_ready=0. Release: in_ready=1 on the next cycle.
// 2. ADD X=16'hFFFF Y=16'h0001, out_ready=1: one cycle later Z=16'h0000, out_valid=1;
//    with ALU_FLAGS_EN, flags C=1, N=0, Z0=1.
// 3. Back-to-back stream: AND, OR, XOR, SUB(5-7) with out_ready=1. One result per cycle;
//    SUB gives Z=16'hFFFE, C=0.
// 4. SHL X=16'h0001 Y=4: in_ready=0 for 4 cycles, then Z=16'h0010. A SHR with Y=0 completes in
//    1 cycle with Z=X.
// 5. Backpressure: out_ready=0 for 5 cycles after a result. Z stays stable and in_ready=0;
//    raise out_ready and present a new op the same cycle: drain and accept happen together.
// 6. Assert reset mid-SHIFT (SHR by 15): out_valid=0 and Z=0 immediately; after release, a new
//    op executes normally.

Source files
------------

// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the ALU execution stage: op-code encodings and a shift-op helper.
// The optional flags output is controlled by the ALU_FLAGS_EN macro in the top.
package alu_exec_stage_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == ALU_SHL) || (op == ALU_SHR);
    endfunction

endpackage

// File: rtl/alu_exec_stage_shift_unit.sv
// Iterative shifter for the ALU execution stage: holds the operand, the remaining count,
// and the direction, and moves the operand one bit per enabled cycle.
module alu_shift_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             left,
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   amt,
    input  logic             step,
    output logic [WIDTH-1:0] step_val,
    output logic             step_bit,
    output logic             last
);

    logic [WIDTH-1:0] sreg;
    logic [SHW-1:0]   cnt;
    logic             left_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg   <= '0;
            cnt    <= '0;
            left_q <= 1'b0;
        end else if (load) begin
            sreg   <= data;
            cnt    <= amt;
            left_q <= left;
        end else if (step && (cnt != '0)) begin
            sreg <= step_val;
            cnt  <= cnt - SHW'(1);
        end
    end

    // step_bit is the bit that leaves the register on this step; it becomes C on the final one.
    assign step_val = left_q ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    assign step_bit = left_q ? sreg[WIDTH-1] : sreg[0];
    assign last     = (cnt == SHW'(1));

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execution stage with valid/ready handshakes and iterative shifts.
// Define ALU_FLAGS_EN to add the {C,N,Z0} flags register alongside Z.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             fsm_state
`ifdef ALU_FLAGS_EN
    ,
    output logic [2:0]       flags
`endif
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state;
    logic             accept;
    logic             shift_start;
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;
    logic             last;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and a new op may be accepted in the cycle Z is drained.
    assign in_ready    = reset && (state == IDLE) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign amt         = Y[SHW-1:0];
    assign shift_start = accept && is_shift(op) && (amt != '0);
    assign fsm_state   = state;

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                sum    = {1'b0, X} + {1'b0, Y};
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            ALU_SUB: begin
                sum    = {1'b0, X} + {1'b0, ~Y} + (WIDTH+1)'(1);
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            ALU_AND: result = X & Y;
            ALU_OR:  result = X | Y;
            ALU_XOR: result = X ^ Y;
            ALU_NOT: result = ~X;
            // Only reached with a zero amount; non-zero shifts go through the shift unit.
            ALU_SHL: result = X;
            ALU_SHR: result = X;
            default: result = '0;
        endcase
    end

    alu_shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (shift_start),
        .left     (op == ALU_SHL),
        .data     (X),
        .amt      (amt),
        .step     (state == SHIFT),
        .step_val (step_val),
        .step_bit (step_bit),
        .last     (last)
    );

`ifndef ALU_FLAGS_EN
    logic unused_flag_bits;
    assign unused_flag_bits = ^{carry, step_bit};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            Z         <= '0;
`ifdef ALU_FLAGS_EN
            flags     <= '0;
`endif
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (shift_start) begin
                            state <= SHIFT;
                        end else begin
                            Z         <= result;
                            out_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
                            flags     <= {carry, result[WIDTH-1], result == '0};
`endif
                        end
                    end
                end
                SHIFT: begin
                    if (last) begin
                        Z         <= step_val;
                        out_valid <= 1'b1;
                        state     <= IDLE;
`ifdef ALU_FLAGS_EN
                        flags     <= {step_bit, step_val[WIDTH-1], step_val == '0};
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus a randomized stream
// scored against a behavioural model of the op set.
module tb_alu_exec_stage;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Z;
    logic         fsm_state;
`ifdef ALU_FLAGS_EN
    logic [2:0]   flags;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [2:0]   expf_q[$];

    alu_exec_stage #(.WIDTH(W), .SHW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (Z),
        .fsm_state (fsm_state)
`ifdef ALU_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: result and {C,N,Z0} from the arithmetic definition of each op.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] z, output logic [2:0] f);
        int unsigned s;
        int          n;
        logic        c;
        n = int'(b[3:0]);
        c = 1'b0;
        z = '0;
        case (o)
            3'd0: begin s = int'(a) + int'(b); z = W'(s % 65536); c = (s >= 65536); end
            3'd1: begin z = W'(int'(a) - int'(b)); c = (a >= b); end
            3'd2: z = a & b;
            3'd3: z = a | b;
            3'd4: z = a ^ b;
            3'd5: z = ~a;
            3'd6: begin z = a << n; if (n > 0) c = a[W-n]; end
            default: begin z = a >> n; if (n > 0) c = a[n-1]; end
        endcase
        f = {c, z[W-1], z == '0};
    endfunction

    // driver: hold an op until accepted (bounded), then drop in_valid
    task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        op = o; X = a; Y = b; in_valid = 1'b1; ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin @(posedge clk); #1; end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; X = '0; Y = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (Z !== '0) begin errors++; $display("FAIL reset_z got=%h exp=0000", Z); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_add_wrap();
        bit ok;
        out_ready = 1'b1;
        send(3'd0, 16'hFFFF, 16'h0001, ok);
        checks++; if (!ok) begin errors++; $display("FAIL add_accept got=timeout exp=accept"); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || Z !== 16'h0000) begin
            errors++; $display("FAIL add_wrap got=v%b z=%h exp=v1 z=0000", out_valid, Z); end
`ifdef ALU_FLAGS_EN
        checks++; if (flags !== 3'b101) begin errors++; $display("FAIL add_flags got=%b exp=101", flags); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops[4];
        logic [W-1:0] xs[4], ys[4], ez[4];
        logic [2:0]   ef[4];
        ops = '{3'd2, 3'd3, 3'd4, 3'd1};
        for (int i = 0; i < 3; i++) begin xs[i] = W'($urandom); ys[i] = W'($urandom); end
        xs[3] = 16'd5; ys[3] = 16'd7;
        for (int i = 0; i < 4; i++) model(ops[i], xs[i], ys[i], ez[i], ef[i]);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin in_valid = 1'b1; op = ops[i]; X = xs[i]; Y = ys[i]; end
            else in_valid = 1'b0;
            @(negedge clk);
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1 || Z !== ez[i-1]) begin
                    errors++; $display("FAIL b2b_result%0d got=v%b z=%h exp=v1 z=%h", i-1, out_valid, Z, ez[i-1]); end
            end
            if (i < 4) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready); end
            end
            if (i == 4) begin
                checks++; if (Z !== 16'hFFFE) begin errors++; $display("FAIL sub_value got=%h exp=fffe", Z); end
`ifdef ALU_FLAGS_EN
                checks++; if (flags[2] !== 1'b0) begin errors++; $display("FAIL sub_carry got=%b exp=0", flags[2]); end
`endif
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_shift();
        bit ok;
        logic [W-1:0] xr;
        out_ready = 1'b1;
        send(3'd6, 16'h0001, 16'h0004, ok);
        checks++; if (!ok) begin errors++; $display("FAIL shl_accept got=timeout exp=accept"); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL shl_busy%0d got=r%b v%b exp=r0 v0", k, in_ready, out_valid); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || Z !== 16'h0010 || in_ready !== 1'b1) begin
            errors++; $display("FAIL shl_result got=v%b z=%h r%b exp=v1 z=0010 r1", out_valid, Z, in_ready); end
        @(posedge clk); #1;
        xr = W'($urandom);
        in_valid = 1'b1; op = 3'd7; X = xr; Y = 16'hA5A0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL shr0_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || Z !== xr) begin
            errors++; $display("FAIL shr0_result got=v%b z=%h exp=v1 z=%h", out_valid, Z, xr); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [W-1:0] a, b, z1, z2;
        logic [2:0] f;
        a = W'($urandom); b = W'($urandom);
        model(3'd4, a, b, z1, f);
        out_ready = 1'b0;
        send(3'd4, a, b, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_accept got=timeout exp=accept"); end
        in_valid = 1'b1; op = 3'd5; X = 16'h1234; Y = 16'h0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || Z !== z1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got=v%b z=%h r%b exp=v1 z=%h r0", k, out_valid, Z, in_ready, z1); end
            @(posedge clk); #1;
        end
        model(3'd0, 16'h1234, 16'h1111, z2, f);
        out_ready = 1'b1; op = 3'd0; X = 16'h1234; Y = 16'h1111;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || Z !== z1) begin
            errors++; $display("FAIL bp_drain_accept got=r%b z=%h exp=r1 z=%h", in_ready, Z, z1); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || Z !== z2) begin
            errors++; $display("FAIL bp_new_result got=v%b z=%h exp=v1 z=%h", out_valid, Z, z2); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_shift();
        bit ok;
        logic [W-1:0] a, b, ez;
        logic [2:0] ef;
        out_ready = 1'b1;
        send(3'd7, 16'hF0F0, 16'h000F, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_shift_accept got=timeout exp=accept"); end
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || Z !== '0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_abort got=v%b z=%h r%b exp=v0 z=0000 r0", out_valid, Z, in_ready); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_result%0d got=%b exp=0", k, out_valid); end
            @(posedge clk); #1;
        end
        a = W'($urandom); b = W'($urandom);
        model(3'd1, a, b, ez, ef);
        send(3'd1, a, b, ok);
        @(negedge clk);
        checks++; if (!ok || out_valid !== 1'b1 || Z !== ez) begin
            errors++; $display("FAIL rst_recover got=v%b z=%h exp=v1 z=%h", out_valid, Z, ez); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int   sent, cyc;
        bit   acc, drn;
        logic [W-1:0] ez, got_z;
        logic [2:0]   ef;
        sent = 0; cyc = 0;
        in_valid = 1'b0;
        while ((sent < 200 || exp_q.size() > 0) && cyc < 6000) begin
            if (!in_valid && sent < 200 && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                op = 3'($urandom_range(0, 7));
                X  = W'($urandom);
                Y  = W'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (drn) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected got=z%h exp=no_result", Z);
                end else begin
                    ez = exp_q.pop_front();
                    ef = expf_q.pop_front();
                    got_z = Z;
                    if (got_z !== ez) begin errors++; $display("FAIL rand_z got=%h exp=%h", got_z, ez); end
`ifdef ALU_FLAGS_EN
                    checks++; if (flags !== ef) begin errors++; $display("FAIL rand_flags got=%b exp=%b", flags, ef); end
`endif
                end
            end
            @(posedge clk); #1;
            if (acc) begin
                model(op, X, Y, ez, ef);
                exp_q.push_back(ez);
                expf_q.push_back(ef);
                sent++;
                in_valid = 1'b0;
            end
            cyc++;
        end
        checks++; if (cyc >= 6000) begin errors++; $display("FAIL rand_timeout got=%0d_pending exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_back_to_back();
        test_shift();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
